bin2bcd_seq_module: RTL and testbench
=====================================

# bin2bcd_seq_module

Sequential binary-to-BCD converter that feeds the two-digit seven-segment display stage. It takes an unsigned binary value and converts it with a shift-and-add-3 (double-dabble) iteration, one bit per clock. It presents the low two decimal digits as packed BCD on `Result[7:0]`, with a flag for values of 100 or more. `Result` is registered and holds steady between conversions, so the display stage can sample it on any cycle.

## Interface

Parameters:
- `IN_W`, default 7: binary input width. Legal range is 1..8. It sets the iteration count.

Ports:
- `CLK`, in, 1: the single clock. All logic is on the rising edge.
- `RST`, in, 1: reset. Synchronous and active-high.
- `Start`, in, 1: conversion request. Sampled only in IDLE.
- `BinIn`, in, `IN_W`: unsigned binary value. Captured on the edge where `Start` is accepted.
- `Busy`, out, 1: high while a conversion is in progress.
- `Done`, out, 1: single-cycle pulse. It marks the cycle in which the new `Result` and `Overflow` become visible.
- `Result`, out, 8: packed BCD. `[7:4]` is tens, `[3:0]` is units. Output of the display-stage input register.
- `Overflow`, out, 1: set when the converted value is 100 or more (hundreds digit not zero).

## Operation

- FSM has three states: IDLE, SHIFT, FIN.
- IDLE:
  - If `Start`=1 at an edge: load the binary shift register with `BinIn`, clear the 12-bit BCD scratch (hundreds/tens/units), clear the iteration counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per clock:
  - For each scratch nibble 5 or greater, add 3, with no carry between nibbles.
  - Then shift `{scratch, binary}` left by 1. The binary MSB enters the units LSB.
  - Increment the counter. After iteration number `IN_W`, go to FIN.
- FIN:
  - Load `Result` from scratch tens/units.
  - Set `Overflow` = (hundreds != 0).
  - Pulse `Done`, return to IDLE.
- Width and arithmetic rules:
  - The counter is wide enough for `IN_W` (4 bits).
  - Scratch hundreds needs only 2 bits for `IN_W` ≤ 8, but is kept as 4 bits.
  - The add-3 is applied before the shift within the same cycle.
- `Result` and `Overflow` change only in FIN or on reset. They hold between conversions.
- `Start` is ignored in SHIFT and FIN. There is no queuing.
- `BinIn` changes after capture have no effect on the conversion in progress.

## Timing

- Reset values:
  - state IDLE
  - `Busy`=0, `Done`=0
  - `Result`=8'h00, `Overflow`=0
  - scratch and counter = 0
- `RST` has priority over everything. Asserting it mid-conversion aborts the conversion and applies the reset values on the next edge. No `Done` pulse is issued.
- With `Start` accepted at edge N:
  - `Busy`=1 from edge N to edge N+`IN_W`+1.
  - SHIFT iterations occur at edges N+1 through N+`IN_W`.
  - FIN is active during the cycle after edge N+`IN_W`.
  - At edge N+`IN_W`+1: `Result`/`Overflow` update, `Done`=1 for exactly one cycle, `Busy`=0.
- Latency from `Start` sampled to `Result` valid is `IN_W`+1 cycles (8 at the default).
- `Done` and the new `Result` appear in the same cycle.
- Back-to-back: if `Start` is held high, it is re-accepted at the first edge in IDLE. The conversion period is `IN_W`+2 cycles (9 at the default).
- Inputs 0 and 2^`IN_W`−1 are legal boundaries. The default maximum, 127, gives `Result`=8'h27 and `Overflow`=1.

## Test plan

- Reset check: assert `RST` for 2 cycles with `Start`=1 → `Busy`=0, `Done`=0, `Result`=8'h00, `Overflow`=0 throughout. After release, the first conversion starts on the next `Start`.
- Value sweep at default width: `BinIn`=0, 9, 10, 99, 100, 127 → `Result` = 00, 09, 10, 99, 00, 27 and `Overflow` = 0, 0, 0, 0, 1, 1. Each `Done` pulse comes exactly 8 cycles after `Start` is sampled.
- Full exhaustive run: all 128 inputs, each checked against a division-based reference model. `Done` is one cycle wide every time.
- `Start` asserted during SHIFT with a different `BinIn` → ignored. `Result` reflects the first value only, and only one `Done` pulse occurs.
- `RST` pulsed at iteration 4 of converting 57, with `Result` previously 8'h42 → `Result` becomes 8'h00, no `Done` pulse. A new `Start` with 57 then yields 8'h57.
- `Start` held high continuously with `BinIn`=63 → `Done` pulses every 9 cycles with `Result`=8'h63. With `IN_W`=8 and `BinIn`=255 → `Result`=8'h55, `Overflow`=1, latency 9 cycles.

Source files
------------

// File: rtl/bin2bcd_seq_module.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) that
// feeds the two-digit display stage with a registered packed-BCD result.
module bin2bcd_seq_module #(
  parameter int unsigned IN_W = 7
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [IN_W-1:0] BinIn,
  output logic            Busy,
  output logic            Done,
  output logic [7:0]      Result,
  output logic            Overflow
);

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  localparam logic [3:0] LastIter = 4'(IN_W - 1);

  state_e          state_q, state_d;
  logic [IN_W-1:0] bin_q, bin_d;
  logic [11:0]     scratch_q, scratch_d, scratch_adj;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      result_q, result_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  // Add-3 correction per nibble, no carry between digits.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (Start) begin
          bin_d     = BinIn;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        scratch_d = {scratch_adj[10:0], bin_q[IN_W-1]};
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LastIter) begin
          state_d = StFin;
        end
      end
      StFin: begin
        result_d   = scratch_q[7:0];
        overflow_d = |scratch_q[11:8];
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign Busy     = (state_q != StIdle);
  assign Done     = done_q;
  assign Result   = result_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq_module.sv
// Directed self-checking bench for bin2bcd_seq_module at IN_W=7 and IN_W=8.
module tb_bin2bcd_seq_module;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] bin_in = '0;
  logic       busy, done, ovf;
  logic [7:0] result;

  logic       start8 = 1'b0;
  logic [7:0] bin_in8 = '0;
  logic       busy8, done8, ovf8;
  logic [7:0] result8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_module #(.IN_W(7)) dut (
    .CLK(clk), .RST(rst), .Start(start), .BinIn(bin_in),
    .Busy(busy), .Done(done), .Result(result), .Overflow(ovf)
  );

  bin2bcd_seq_module #(.IN_W(8)) dut8 (
    .CLK(clk), .RST(rst), .Start(start8), .BinIn(bin_in8),
    .Busy(busy8), .Done(done8), .Result(result8), .Overflow(ovf8)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion on the 7-bit DUT and wait (bounded) for Done.
  task automatic convert(input int v, output int lat);
    start  = 1'b1;
    bin_in = 7'(v);
    tick();
    start  = 1'b0;
    check("busy_after_start", int'(busy), 1);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic convert_check(input int v);
    int lat;
    int exp_res;
    convert(v, lat);
    exp_res = ((v / 10) % 10) * 16 + (v % 10);
    check("latency", lat, 8);
    check("result", int'(result), exp_res);
    check("overflow", int'(ovf), (v >= 100) ? 1 : 0);
    check("busy_at_done", int'(busy), 0);
    tick();
    check("done_one_cycle", int'(done), 0);
  endtask

  int sweep_in [6]  = '{0, 9, 10, 99, 100, 127};
  int sweep_res [6] = '{'h00, 'h09, 'h10, 'h99, 'h00, 'h27};
  int sweep_ovf [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    int lat;
    int pulses;
    int last;

    // Reset held with Start high.
    start = 1'b1;
    bin_in = 7'd55;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 'h00);
      check("rst_ovf", int'(ovf), 0);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("idle_after_rst", int'(busy), 0);

    // Directed sweep.
    for (int i = 0; i < 6; i++) begin
      convert(sweep_in[i], lat);
      check("sweep_lat", lat, 8);
      check("sweep_res", int'(result), sweep_res[i]);
      check("sweep_ovf", int'(ovf), sweep_ovf[i]);
      tick();
    end

    // Exhaustive against a division model.
    for (int v = 0; v < 128; v++) begin
      convert_check(v);
    end

    // Start during SHIFT with a different value must be ignored.
    start = 1'b1;
    bin_in = 7'd33;
    tick();
    start = 1'b0;
    bin_in = 7'd77;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) begin
        pulses++;
        check("ignore_start_res", int'(result), 'h33);
      end
    end
    check("ignore_start_pulses", pulses, 1);

    // Reset at iteration 4 aborts; no Done; a fresh start still works.
    convert(42, lat);
    check("pre_abort_res", int'(result), 'h42);
    tick();
    start = 1'b1;
    bin_in = 7'd57;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_res", int'(result), 'h00);
    check("abort_busy", int'(busy), 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    convert(57, lat);
    check("after_abort_lat", lat, 8);
    check("after_abort_res", int'(result), 'h57);
    tick();

    // Start held high: one Done every 9 cycles.
    start = 1'b1;
    bin_in = 7'd63;
    pulses = 0;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) begin
        pulses++;
        check("b2b_res", int'(result), 'h63);
        if (last >= 0) check("b2b_period", c - last, 9);
        last = c;
      end
    end
    start = 1'b0;
    check("b2b_pulses", pulses, 4);
    for (int k = 0; k < 10; k++) tick();

    // 8-bit instance: 255 -> 55 with overflow, latency 9.
    start8 = 1'b1;
    bin_in8 = 8'd255;
    tick();
    start8 = 1'b0;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done8) begin
        lat = k;
        break;
      end
    end
    check("w8_lat", lat, 9);
    check("w8_res", int'(result8), 'h55);
    check("w8_ovf", int'(ovf8), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
